// File: rtl/max_finder_4b_pkg.sv
// Shared types for the streaming running-maximum unit.
// Element width and element type used by the top and the comparator.
package max_finder_4b_pkg;
    localparam int DATA_W = 4;
    typedef logic [DATA_W-1:0] data_t;
endpackage

// File: rtl/max_finder_4b_if.sv
// Input element stream and output result stream of max_finder_4b.
// master drives elements and accepts results; slave is the finder.
interface max_finder_4b_if
    import max_finder_4b_pkg::*;
#(
    parameter int NUM_ELEMS = 8,
    localparam int IDX_W = $clog2(NUM_ELEMS)
) ();
    logic             in_val;
    logic             in_rdy;
    data_t            in_data;
    logic             out_val;
    logic             out_rdy;
    data_t            out_max;
    logic [IDX_W-1:0] out_idx;

    modport master (
        output in_val, in_data, out_rdy,
        input  in_rdy, out_val, out_max, out_idx
    );

    modport slave (
        input  in_val, in_data, out_rdy,
        output in_rdy, out_val, out_max, out_idx
    );
endinterface

// File: rtl/max_finder_4b_gt.sv
// Team 4-bit unsigned strict greater-than comparator.
// gt is high only when in0 is strictly larger than in1.
module GTComparator_4b_RTL
    import max_finder_4b_pkg::*;
(
    input  data_t in0,
    input  data_t in1,
    output logic  gt
);
    assign gt = in0 > in1;
endmodule

// File: rtl/max_finder_4b.sv
// Running maximum over a fixed-length frame of 4-bit elements.
// Reports the largest value and its earliest position after the last element.
module max_finder_4b
    import max_finder_4b_pkg::*;
#(
    parameter int NUM_ELEMS = 8,
    localparam int IDX_W = $clog2(NUM_ELEMS)
) (
    input logic            clk,
    input logic            rst,
    max_finder_4b_if.slave bus
);
    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_ELEMS - 1);

    state_t           state;
    logic [IDX_W-1:0] count;
    logic [IDX_W-1:0] idx_reg;
    data_t            max_reg;
    logic             gt;
    logic             take;

    GTComparator_4b_RTL u_gt (
        .in0 (bus.in_data),
        .in1 (max_reg),
        .gt  (gt)
    );

    // Readiness is masked by reset so nothing is offered while state is cleared
    assign bus.in_rdy  = rst && (state == ACCUM);
    assign bus.out_val = (state == DONE);
    assign bus.out_max = max_reg;
    assign bus.out_idx = idx_reg;
    assign take        = bus.in_val && bus.in_rdy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state   <= ACCUM;
            count   <= '0;
            max_reg <= '0;
            idx_reg <= '0;
        end else begin
            unique case (state)
                ACCUM: begin
                    if (take) begin
                        // Strict gt keeps the earliest index on ties
                        if (count == '0) begin
                            max_reg <= bus.in_data;
                            idx_reg <= '0;
                        end else if (gt) begin
                            max_reg <= bus.in_data;
                            idx_reg <= count;
                        end
                        if (count == LAST) begin
                            state <= DONE;
                            count <= '0;
                        end else begin
                            count <= count + 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (bus.out_rdy) state <= ACCUM;
                end
                default: state <= ACCUM;
            endcase
        end
    end
endmodule
